// File: rtl/fsm_debouncer.sv
// fsm_debouncer: 4-state FSM plus stability counter that turns a bouncing level into a clean registered level.
// Define DEBOUNCER_SYNC_EN to insert a 2-FF synchronizer ahead of the FSM (adds 2 cycles of latency).
module fsm_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_signal,
  output logic o_out,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // One-hot encoding so that corrupted states are detectable and fall into the recovery branch.
  typedef enum logic [3:0] {
    ST_LOW       = 4'b0001,
    ST_WAIT_HIGH = 4'b0010,
    ST_HIGH      = 4'b0100,
    ST_WAIT_LOW  = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             s;

`ifdef DEBOUNCER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_signal};
    end
  end

  assign s = sync_q[1];
`else
  assign s = i_signal;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so the port flops change on the same edge as the state register.
  always_comb begin
    out_d  = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      ST_WAIT_HIGH: busy_d = 1'b1;
      ST_HIGH:      out_d  = 1'b1;
      ST_WAIT_LOW: begin
        out_d  = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_out  = out_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_fsm_debouncer.sv
// Self-checking bench for fsm_debouncer: table-driven vectors through a scoreboard queue plus
// hand-written reset sequences. Latency adapts to whether DEBOUNCER_SYNC_EN is defined.
module tb_fsm_debouncer;

  localparam int STABLE = 4;
`ifdef DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic i_signal = 1'b0;
  logic o_out;
  logic o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic  sig;
    logic  glitch;
    logic  exp_out;
    logic  exp_busy;
    string tag;
  } vec_t;

  typedef struct {
    logic  exp_out;
    logic  exp_busy;
    string tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  fsm_debouncer #(.STABLE_CYCLES(STABLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_signal (i_signal),
    .o_out    (o_out),
    .o_busy   (o_busy)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic void add(input logic sig, input logic glitch, input logic eo,
                              input logic eb, input string tag);
    vec_t v;
    v.sig      = sig;
    v.glitch   = glitch;
    v.exp_out  = eo;
    v.exp_busy = eb;
    v.tag      = tag;
    vecs.push_back(v);
  endfunction

  // Drive one vector half a cycle before the edge, then compare #1 after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    i_signal   = v.sig;
    e.exp_out  = v.exp_out;
    e.exp_busy = v.exp_busy;
    e.tag      = $sformatf("%s[%0d]", v.tag, idx);
    sb_q.push_back(e);
    if (v.glitch) begin
      #3 i_signal = 1'b1;
      #3 i_signal = 1'b0;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, expected one entry");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".out"}, o_out, e.exp_out);
      check({e.tag, ".busy"}, o_busy, e.exp_busy);
      $display("[%0t] %s sig=%b out=%b busy=%b exp_out=%b exp_busy=%b",
               $time, e.tag, v.sig, o_out, o_busy, e.exp_out, e.exp_busy);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    vecs.delete();
  endtask

  // Clean transition: busy on edges [LAT, LAT+STABLE), output flips at LAT+STABLE.
  function automatic void add_rise(input string tag);
    for (int k = 0; k < 10; k++)
      add(1'b1, 1'b0, (k >= LAT + STABLE), (k >= LAT && k < LAT + STABLE), tag);
  endfunction

  initial begin
    // Power-on reset: low pulse of 3 ns at t=2 ns.
    #2 rst = 1'b0;
    #2;
    check("reset_hold.out", o_out, 1'b0);
    check("reset_hold.busy", o_busy, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("reset_rel.out", o_out, 1'b0);
    check("reset_rel.busy", o_busy, 1'b0);

    for (int k = 0; k < 20; k++) add(1'b0, 1'b0, 1'b0, 1'b0, "quiet");
    add_rise("rise");
    for (int k = 0; k < 10; k++)
      add(1'b0, 1'b0, (k < LAT + STABLE), (k >= LAT && k < LAT + STABLE), "fall");
    add(1'b0, 1'b1, 1'b0, 1'b0, "glitch");
    for (int k = 0; k < 5; k++) add(1'b0, 1'b0, 1'b0, 1'b0, "post_glitch");
    for (int k = 0; k < 10; k++)
      add((k < 3), 1'b0, 1'b0, (k >= LAT && k < LAT + 3), "short");
    add_rise("rise2");
    // Raw: low, low, high, then low; the final low reaches the FSM at LAT+3.
    for (int k = 0; k < 14; k++)
      add((k == 2), 1'b0, (k < LAT + 3 + STABLE),
          ((k >= LAT && k < LAT + 2) || (k >= LAT + 3 && k < LAT + 3 + STABLE)), "bounce");
    run_table();

    // Reset while WAIT_HIGH holds cnt=2.
    for (int k = 0; k <= LAT + 2; k++) add(1'b1, 1'b0, 1'b0, (k >= LAT), "pre_rst");
    run_table();
    #2 rst = 1'b0;
    #1;
    check("midrst.out", o_out, 1'b0);
    check("midrst.busy", o_busy, 1'b0);
    #3 rst = 1'b1;
    add_rise("post_rst");
    run_table();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_debouncer.md
# fsm_debouncer

Input-conditioning stage placed directly upstream of `flank_detector`. Filters a noisy, asynchronous level input, such as a push-button, through a 4-state FSM and a stability counter. Drives a clean, registered level `o_out` that connects straight to `flank_detector.i_signal`. A level change propagates only after the input has been sampled at the new value on `STABLE_CYCLES+1` consecutive rising edges.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of counted stable cycles after the first new-value sample. Legal range is ≥1.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: counter width, minimum 1. Derived; do not override.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset. Assert at any time; deassertion is synchronous to `clk` at system level.
- `i_signal`  in  1: raw, possibly asynchronous and bouncing level.
- `o_out`  out  1: debounced level, registered.
- `o_busy`  out  1: high while a candidate transition is being qualified, registered.

## Operation
- Let `s` be the FSM sample input.
  - With `DEBOUNCER_SYNC_EN`, `s` is the output of a 2-FF synchronizer on `i_signal`.
  - Without the macro, `s` is `i_signal` directly.
- The FSM has 4 states plus counter `cnt[CNT_W-1:0]`.
- LOW state:
  - `o_out=0`, `o_busy=0`.
  - If `s=1`, go to WAIT_HIGH and set `cnt<=0`.
- WAIT_HIGH state:
  - `o_out=0`, `o_busy=1`.
  - If `s=0`, go to LOW. This aborts the qualification; the count does not carry over.
  - Else if `cnt==STABLE_CYCLES-1`, go to HIGH.
  - Else `cnt<=cnt+1`.
- HIGH state:
  - `o_out=1`, `o_busy=0`.
  - If `s=0`, go to WAIT_LOW and set `cnt<=0`.
- WAIT_LOW state:
  - `o_out=1`, `o_busy=1`.
  - If `s=1`, go to HIGH.
  - Else if `cnt==STABLE_CYCLES-1`, go to LOW.
  - Else `cnt<=cnt+1`.
- `o_out` and `o_busy` are flops, updated on the same edge as the state register. They are never decoded combinationally to the ports, so they carry no glitches.
- The counter never wraps. Its maximum value is `STABLE_CYCLES-1`, which fits in `CNT_W` bits.
- Unused and illegal state encodings recover to LOW on the next edge, with `o_out=0` and `o_busy=0`.
- Reset:
  - Asserting `rst` low immediately forces LOW, `cnt=0`, synchronizer flops 0, `o_out=0` and `o_busy=0`.
  - Reset asserted mid-qualification discards all progress.
  - After release, a full qualification is required even if `i_signal` is already high.

## Timing
- Edge 0 is the first rising edge at which the raw input is captured at its new value. Everything below assumes the input stays stable from edge 0 onward.
- Without the macro:
  - WAIT state is entered at edge 0.
  - `o_out` toggles at edge `STABLE_CYCLES`.
  - Latency is `STABLE_CYCLES` cycles.
- With the macro:
  - Add 2 cycles: WAIT state is entered at edge 2 and `o_out` toggles at edge `STABLE_CYCLES+2`.
- `o_busy` rises on the WAIT-entry edge and falls on the edge on which `o_out` toggles, or on the edge that aborts the wait.
- Pulse filtering:
  - Any input pulse sampled fewer than `STABLE_CYCLES+1` consecutive times produces no `o_out` change.
  - An input pulse that falls between two rising edges is never sampled and produces no `o_out` change.
- `o_out` changes at most once per `STABLE_CYCLES+1` cycles.
- Downstream, `flank_detector` sees clean, single-cycle-aligned transitions.

## Configuration
- `DEBOUNCER_SYNC_EN`, when defined, compiles in the 2-FF metastability synchronizer. Latency then gains 2 cycles. This is the required setting for any pin-connected input.
- When the macro is undefined, there is no synchronizer and `i_signal` feeds the FSM directly. Use this only when the input is already synchronous to `clk`.

## Test plan
All scenarios use `STABLE_CYCLES=4`, `DEBOUNCER_SYNC_EN` defined, a 20 ns clock period, and reset pulsed low for 3 ns at t=2 ns.
- **Quiet input:** reset, then hold `i_signal=0` for 20 cycles. Required: `o_out=0` and `o_busy=0` throughout.
- **Clean rise:** `i_signal` goes 0→1 and holds for 10 cycles. Required: `o_busy` goes to 1 at edge 2 and back to 0 at edge 6; `o_out` goes to 1 at edge 6.
- **Sub-cycle glitch:** a 3 ns high pulse placed between two rising edges. Required: no change on `o_out` or `o_busy`.
- **Short pulse:** `i_signal` high for exactly 3 edges, then low. Required: `o_busy` high for 3 cycles; `o_out` stays 0.
- **Bounce on release:** with `o_out=1`, drive `i_signal` low for 2 edges, high for 1 edge, then low and hold. Required:
  - `o_out` stays 1 through the bounce.
  - `o_out` falls 4 cycles after the final low enters WAIT_LOW.
- **Reset mid-qualification:** assert `rst` low while in WAIT_HIGH with `cnt=2`. Required:
  - `o_out=0` and `o_busy=0` immediately.
  - After release with input still high, `o_out` rises only at edge 6 counted from the first post-reset edge.
